branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameters SHALL be: REG_SZ 5, register-address width; CNT_SZ 16, statistics counter width.
REQ-002 Ports SHALL be, in this order:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_branch_eq  in  1  BEQ decoded in ID.
- i_branch_ne  in  1  BNE decoded in ID.
- i_jump  in  1  unconditional jump decoded in ID.
- i_rs  in  REG_SZ  branch source register rs.
- i_rt  in  REG_SZ  branch source register rt.
- i_ex_reg_write  in  1  instruction in EX writes a register.
- i_ex_mem_read  in  1  instruction in EX is a load.
- i_ex_rd  in  REG_SZ  EX destination register.
- i_mem_mem_read  in  1  instruction in MEM is a load.
- i_mem_rd  in  REG_SZ  MEM destination register.
- i_comparison  in  1  ID equality result (1 = operands equal, after forwarding).
- o_stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- o_flush  out  1  squash instruction in IF/ID.
- o_pc_src  out  1  select branch/jump target for next PC.
- o_branch_count  out  CNT_SZ  conditional branches resolved.
- o_taken_count  out  CNT_SZ  conditional branches taken.
- o_stall_count  out  CNT_SZ  cycles with o_stall=1.

Function
REQ-003 Match(x) SHALL be: x != 0 and (x == i_rs or x == i_rt).
REQ-004 need SHALL be: 2 if i_ex_mem_read and Match(i_ex_rd); else 1 if (i_ex_reg_write and Match(i_ex_rd)) or (i_mem_mem_read and Match(i_mem_rd)); else 0.
REQ-005 br SHALL be i_branch_eq or i_branch_ne; if both are 1, BEQ semantics apply.
REQ-006 taken SHALL be i_comparison for BEQ and not i_comparison for BNE.
REQ-007 FSM states SHALL be IDLE, STALL, RESOLVE, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-008 IDLE, br, need=0: o_pc_src=o_flush=taken in the same cycle; state stays IDLE.
REQ-009 IDLE, br, need=1: o_stall=1, o_pc_src=o_flush=0; next state RESOLVE.
REQ-010 IDLE, br, need=2: o_stall=1, o_pc_src=o_flush=0; next state STALL.
REQ-011 STALL: o_stall=1 regardless of inputs; next state RESOLVE.
REQ-012 RESOLVE: o_stall=0, o_pc_src=o_flush=taken; hazard inputs are ignored; next state IDLE.
REQ-013 i_jump in IDLE with br=0: o_pc_src=1, o_flush=1, no stall; i_jump is ignored in STALL and RESOLVE.
REQ-014 If i_jump and br are both 1 in IDLE, the branch SHALL take priority and i_jump is ignored.
REQ-015 o_stall, o_flush and o_pc_src SHALL be combinational functions of state and inputs, with zero-cycle latency.
REQ-016 o_stall and o_flush SHALL never both be 1.
REQ-017 o_branch_count SHALL increment on each resolution cycle (REQ-008, REQ-012) and o_taken_count on each such cycle where taken=1.
REQ-018 o_stall_count SHALL increment on every cycle with o_stall=1.
REQ-019 All counters SHALL saturate at 2^CNT_SZ-1 and never wrap.

Reset
REQ-020 While i_reset=0: state SHALL be IDLE, all counters 0, and o_stall/o_flush/o_pc_src forced to 0 irrespective of inputs.
REQ-021 Reset asserted in STALL or RESOLVE SHALL abandon the pending branch with no resolution and no counter update; after release the block starts in IDLE.

Verification
REQ-022 BEQ, rs=3 rt=4, no hazard, i_comparison=1 -> same cycle o_pc_src=1, o_flush=1, o_stall=0; branch_count=1, taken_count=1.
REQ-023 BNE, EX ALU writes rd=3 = rs, i_comparison=1 -> cycle0 o_stall=1; cycle1 RESOLVE o_pc_src=0, o_flush=0; stall_count=1, taken_count=0.
REQ-024 BEQ, EX load with rd=4 = rt -> o_stall=1 for 2 cycles (IDLE, STALL); then RESOLVE with i_comparison=1 gives o_pc_src=1; stall_count=2.
REQ-025 BEQ, EX writes rd=0 = rs=0 -> no stall; resolves immediately.
REQ-026 i_reset pulsed low during STALL -> outputs 0 immediately, counters 0, state IDLE; a later no-hazard branch resolves in 1 cycle.
REQ-027 CNT_SZ=4, 20 consecutive stalled branches -> o_stall_count holds at 15.

Source files
------------

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//   ID-stage branch/jump controller for a 5-stage pipeline. Detects data
//   hazards on the branch source registers and stalls ID until the operands
//   can be forwarded. It then resolves BEQ/BNE and raises the PC-select and
//   IF/ID flush. Unconditional jumps redirect the PC immediately. Three
//   saturating statistics counters track the branch, taken and stall events.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_branch_eq/ne        conditional branch decoded in ID (BEQ wins if both)
//   i_jump                unconditional jump decoded in ID
//   i_rs, i_rt            branch source registers
//   i_ex_reg_write        EX writes a register (ALU result forwardable next cycle)
//   i_ex_mem_read         EX is a load (two cycles before data is forwardable)
//   i_ex_rd               EX destination register
//   i_mem_mem_read        MEM is a load (one cycle before data is forwardable)
//   i_mem_rd              MEM destination register
//   i_comparison          ID equality result after forwarding
//   o_stall               hold PC and IF/ID, bubble into ID/EX
//   o_flush               squash the instruction in IF/ID
//   o_pc_src              select branch/jump target for next PC
//   o_branch_count        conditional branches resolved (saturating)
//   o_taken_count         conditional branches taken (saturating)
//   o_stall_count         cycles with o_stall=1 (saturating)
// ---------------------------------------------------------------------------
module branch_ctrl #(
    parameter int REG_SZ = 5,
    parameter int CNT_SZ = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_branch_eq,
    input  logic              i_branch_ne,
    input  logic              i_jump,
    input  logic [REG_SZ-1:0] i_rs,
    input  logic [REG_SZ-1:0] i_rt,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_read,
    input  logic [REG_SZ-1:0] i_ex_rd,
    input  logic              i_mem_mem_read,
    input  logic [REG_SZ-1:0] i_mem_rd,
    input  logic              i_comparison,
    output logic              o_stall,
    output logic              o_flush,
    output logic              o_pc_src,
    output logic [CNT_SZ-1:0] o_branch_count,
    output logic [CNT_SZ-1:0] o_taken_count,
    output logic [CNT_SZ-1:0] o_stall_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STALL   = 2'b01,
        RESOLVE = 2'b10
    } state_t;

    localparam logic [CNT_SZ-1:0] CNT_MAX = {CNT_SZ{1'b1}};

    state_t state;
    state_t state_nxt;

    logic       br;
    logic       taken;
    logic       ex_match;
    logic       mem_match;
    logic [1:0] need;       // stall cycles still required before resolving
    logic       resolve;
    logic       stall_raw;
    logic       flush_raw;
    logic       pc_src_raw;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    assign ex_match  = (i_ex_rd  != '0) && ((i_ex_rd  == i_rs) || (i_ex_rd  == i_rt));
    assign mem_match = (i_mem_rd != '0) && ((i_mem_rd == i_rs) || (i_mem_rd == i_rt));

    always_comb begin
        need = 2'd0;
        if (i_ex_mem_read && ex_match) begin
            need = 2'd2;
        end else if ((i_ex_reg_write && ex_match) || (i_mem_mem_read && mem_match)) begin
            need = 2'd1;
        end
    end

    assign br    = i_branch_eq || i_branch_ne;
    // BEQ semantics win when both decode bits are set.
    assign taken = i_branch_eq ? i_comparison : (i_branch_ne && !i_comparison);

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (br && need == 2'd2) begin
                    state_nxt = STALL;
                end else if (br && need == 2'd1) begin
                    state_nxt = RESOLVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            STALL:   state_nxt = RESOLVE;
            RESOLVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; jumps are only honoured in IDLE without a branch.
    always_comb begin
        stall_raw  = 1'b0;
        flush_raw  = 1'b0;
        pc_src_raw = 1'b0;
        resolve    = 1'b0;
        case (state)
            IDLE: begin
                if (br) begin
                    if (need == 2'd0) begin
                        flush_raw  = taken;
                        pc_src_raw = taken;
                        resolve    = 1'b1;
                    end else begin
                        stall_raw  = 1'b1;
                    end
                end else if (i_jump) begin
                    flush_raw  = 1'b1;
                    pc_src_raw = 1'b1;
                end
            end
            STALL: begin
                stall_raw = 1'b1;
            end
            RESOLVE: begin
                flush_raw  = taken;
                pc_src_raw = taken;
                resolve    = 1'b1;
            end
            default: begin
                stall_raw = 1'b0;
            end
        endcase
    end

    // Reset masks the control outputs combinationally, not just via state.
    assign o_stall  = i_reset && stall_raw;
    assign o_flush  = i_reset && flush_raw;
    assign o_pc_src = i_reset && pc_src_raw;

    // Saturating statistics counters
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_branch_count <= '0;
            o_taken_count  <= '0;
            o_stall_count  <= '0;
        end else begin
            if (resolve && o_branch_count != CNT_MAX) begin
                o_branch_count <= o_branch_count + 1'b1;
            end
            if (resolve && taken && o_taken_count != CNT_MAX) begin
                o_taken_count <= o_taken_count + 1'b1;
            end
            if (o_stall && o_stall_count != CNT_MAX) begin
                o_stall_count <= o_stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
//   Directed bench for branch_ctrl. Two instances share all inputs: dut with
//   16-bit counters and dut4 with 4-bit counters for the saturation case.
//   Inputs change 1 time unit after a rising edge; outputs are compared
//   1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

    localparam int REG_SZ = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              beq, bne, jmp, exw, exl, meml, cmp;
    logic [REG_SZ-1:0] rs, rt, exrd, memrd;
    logic              stall, flush, pc_src;
    logic [15:0]       br_cnt, tk_cnt, st_cnt;
    logic              stall4, flush4, pc_src4;
    logic [3:0]        br_cnt4, tk_cnt4, st_cnt4;

    int checks   = 0;
    int failures = 0;

    branch_ctrl #(.REG_SZ(REG_SZ), .CNT_SZ(16)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_branch_eq(beq), .i_branch_ne(bne), .i_jump(jmp),
        .i_rs(rs), .i_rt(rt),
        .i_ex_reg_write(exw), .i_ex_mem_read(exl), .i_ex_rd(exrd),
        .i_mem_mem_read(meml), .i_mem_rd(memrd),
        .i_comparison(cmp),
        .o_stall(stall), .o_flush(flush), .o_pc_src(pc_src),
        .o_branch_count(br_cnt), .o_taken_count(tk_cnt), .o_stall_count(st_cnt)
    );

    branch_ctrl #(.REG_SZ(REG_SZ), .CNT_SZ(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n),
        .i_branch_eq(beq), .i_branch_ne(bne), .i_jump(jmp),
        .i_rs(rs), .i_rt(rt),
        .i_ex_reg_write(exw), .i_ex_mem_read(exl), .i_ex_rd(exrd),
        .i_mem_mem_read(meml), .i_mem_rd(memrd),
        .i_comparison(cmp),
        .o_stall(stall4), .o_flush(flush4), .o_pc_src(pc_src4),
        .o_branch_count(br_cnt4), .o_taken_count(tk_cnt4), .o_stall_count(st_cnt4)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b_eq, input logic b_ne, input logic j,
                         input logic [REG_SZ-1:0] r_s, input logic [REG_SZ-1:0] r_t,
                         input logic e_w, input logic e_l, input logic [REG_SZ-1:0] e_rd,
                         input logic m_l, input logic [REG_SZ-1:0] m_rd, input logic c);
        beq = b_eq; bne = b_ne; jmp = j; rs = r_s; rt = r_t;
        exw = e_w; exl = e_l; exrd = e_rd; meml = m_l; memrd = m_rd; cmp = c;
        #1;
    endtask

    task automatic idle_inputs();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_out(input string tag, input logic s, input logic f, input logic p);
        check({tag, ".stall"},  32'(stall),  32'(s));
        check({tag, ".flush"},  32'(flush),  32'(f));
        check({tag, ".pc_src"}, 32'(pc_src), 32'(p));
    endtask

    task automatic check_cnt(input string tag, input int b, input int t, input int s);
        check({tag, ".branch_count"}, 32'(br_cnt), 32'(b));
        check({tag, ".taken_count"},  32'(tk_cnt), 32'(t));
        check({tag, ".stall_count"},  32'(st_cnt), 32'(s));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with a hazarded branch on the inputs: outputs must stay 0.
        rst_n = 1'b0;
        drive(1, 0, 1, 3, 4, 0, 1, 3, 0, 0, 1);
        check_out("reset", 0, 0, 0);
        check_cnt("reset", 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        check_out("idle", 0, 0, 0);
        tick();

        // BEQ, no hazard, equal -> taken immediately.
        drive(1, 0, 0, 3, 4, 0, 0, 0, 0, 0, 1);
        check_out("beq_nohaz", 0, 1, 1);
        tick();
        idle_inputs();
        check_cnt("beq_nohaz", 1, 1, 0);

        // BNE, EX ALU writes rs -> one stall, then resolve not taken.
        drive(0, 1, 0, 3, 5, 1, 0, 3, 0, 0, 1);
        check_out("bne_ex_c0", 1, 0, 0);
        tick();
        check_out("bne_ex_c1", 0, 0, 0);
        tick();
        idle_inputs();
        check_cnt("bne_ex", 2, 1, 1);

        // BEQ, EX load writes rt -> two stalls, then resolve taken.
        drive(1, 0, 0, 1, 4, 0, 1, 4, 0, 0, 1);
        check_out("beq_ld_c0", 1, 0, 0);
        tick();
        check_out("beq_ld_c1", 1, 0, 0);
        tick();
        check_out("beq_ld_c2", 0, 1, 1);
        tick();
        idle_inputs();
        check_cnt("beq_ld", 3, 2, 3);

        // BEQ, EX writes r0 which equals rs=0 -> no stall, not taken.
        drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        check_out("beq_r0", 0, 0, 0);
        tick();
        idle_inputs();
        check_cnt("beq_r0", 4, 2, 3);

        // Plain jump.
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_out("jump", 0, 1, 1);
        tick();
        idle_inputs();
        check_cnt("jump", 4, 2, 3);

        // Jump together with a not-taken BEQ: branch wins.
        drive(1, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        check_out("jump_beq", 0, 0, 0);
        tick();

        // BEQ and BNE both set, equal: BEQ semantics -> taken.
        drive(1, 1, 0, 2, 3, 0, 0, 0, 0, 0, 1);
        check_out("beq_bne", 0, 1, 1);
        tick();
        idle_inputs();
        check_cnt("beq_bne", 6, 3, 3);

        // MEM load hazard -> one stall; jump in RESOLVE is ignored.
        drive(1, 0, 0, 7, 2, 0, 0, 0, 1, 7, 0);
        check_out("mem_ld_c0", 1, 0, 0);
        tick();
        drive(1, 0, 1, 7, 2, 0, 0, 0, 1, 7, 0);
        check_out("mem_ld_c1", 0, 0, 0);
        tick();
        idle_inputs();
        check_cnt("mem_ld", 7, 3, 4);

        // Reset pulsed in STALL: pending branch abandoned.
        drive(1, 0, 0, 2, 9, 0, 1, 2, 0, 0, 1);
        check_out("rst_stall_c0", 1, 0, 0);
        tick();
        check_out("rst_stall_c1", 1, 0, 0);
        rst_n = 1'b0;
        #1;
        check_out("rst_in_stall", 0, 0, 0);
        check_cnt("rst_in_stall", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 0, 0, 2, 9, 0, 0, 0, 0, 0, 1);
        check_out("after_rst", 0, 1, 1);
        tick();
        idle_inputs();
        check_cnt("after_rst", 1, 1, 0);

        // 20 single-stall taken branches: 4-bit counters saturate at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 5, 6, 1, 0, 6, 0, 0, 1);
            tick();
            tick();
        end
        idle_inputs();
        check_cnt("sat16", 21, 21, 20);
        check("sat4.stall_count",  32'(st_cnt4), 32'd15);
        check("sat4.branch_count", 32'(br_cnt4), 32'd15);
        check("sat4.taken_count",  32'(tk_cnt4), 32'd15);
        tick();
        check("sat4.hold", 32'(st_cnt4), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
